// File: rtl/store_db_rd_if.sv
// -----------------------------------------------------------------------------
// store_db_rd_if
// Output stream of the deblocked-pixel store read engine.
//   out_valid_o  word valid
//   out_ready_i  downstream accepts word
//   out_data_o   32-pixel word
//   out_last_o   final word of the LCU, qualified by out_valid_o
// master: the engine (drives valid/data/last), slave: the memory write master.
// -----------------------------------------------------------------------------
interface store_db_rd_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic [32*PIXEL_WIDTH-1:0]  out_data_o;
    logic                       out_last_o;

    modport master (
        output out_valid_o,
        output out_data_o,
        output out_last_o,
        input  out_ready_i
    );

    modport slave (
        input  out_valid_o,
        input  out_data_o,
        input  out_last_o,
        output out_ready_i
    );
endinterface

// File: rtl/store_db_rd.sv
// -----------------------------------------------------------------------------
// store_db_rd
// Sweeps the deblocking buffer's read port once per completed LCU, absorbs the
// one-cycle RAM latency in a 2-entry output FIFO and presents the words on a
// valid/ready stream. store_done_o pulses once the last word has left.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   store_ready_i   full LCU buffer available (level, sampled in IDLE only)
//   store_en_o      buffer read enable
//   store_addr_o    buffer read word address
//   store_data_i    read data, valid the cycle after store_en_o
//   store_done_o    one-cycle pulse, LCU fully consumed
//   busy_o          engine not in IDLE
//   out             output stream (store_db_rd_if.master)
//
// state | meaning
// IDLE  | waiting for store_ready_i; address restarts at 0 on exit
// RUN   | issuing reads 0..NUM_WORDS-1, gated by FIFO space
// DRAIN | all reads issued, waiting for the last word to be accepted
// DONE  | store_done_o high for one cycle
// -----------------------------------------------------------------------------
module store_db_rd #(
    parameter int PIXEL_WIDTH = 8,
    parameter int NUM_WORDS   = 192
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      store_ready_i,
    output logic                      store_en_o,
    output logic [7:0]                store_addr_o,
    input  logic [32*PIXEL_WIDTH-1:0] store_data_i,
    output logic                      store_done_o,
    output logic                      busy_o,
    store_db_rd_if.master             out
);
    localparam int         DW        = 32*PIXEL_WIDTH;
    localparam logic [7:0] LAST_ADDR = 8'(NUM_WORDS-1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic            rd_pending;
    logic            rd_pending_last;
    logic            skid_valid;
    logic            skid_last;
    logic [DW-1:0]   skid_data;
    logic            pop;
    logic [2:0]      occ_after_pop;

    // Occupancy counts the read in flight so that a returning word always
    // finds a free FIFO slot.
    assign pop           = out.out_valid_o & out.out_ready_i;
    assign occ_after_pop = {2'b0, out.out_valid_o} + {2'b0, skid_valid}
                         + {2'b0, rd_pending} - {2'b0, pop};
    assign store_en_o    = (state == RUN) && (occ_after_pop < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            store_addr_o <= '0;
            store_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            store_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (store_ready_i) begin
                        state        <= RUN;
                        store_addr_o <= '0;
                        busy_o       <= 1'b1;
                    end
                end
                RUN: begin
                    if (store_en_o) begin
                        if (store_addr_o == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            store_addr_o <= store_addr_o + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out.out_last_o) begin
                        state        <= DONE;
                        store_done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Head register drives the stream directly; the skid entry catches a
    // returning word while the head is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pending      <= 1'b0;
            rd_pending_last <= 1'b0;
            out.out_valid_o <= 1'b0;
            out.out_data_o  <= '0;
            out.out_last_o  <= 1'b0;
            skid_valid      <= 1'b0;
            skid_data       <= '0;
            skid_last       <= 1'b0;
        end else begin
            rd_pending      <= store_en_o;
            rd_pending_last <= store_en_o && (store_addr_o == LAST_ADDR);
            if (!out.out_valid_o || pop) begin
                if (skid_valid) begin
                    out.out_data_o  <= skid_data;
                    out.out_last_o  <= skid_last;
                    out.out_valid_o <= 1'b1;
                    skid_valid      <= rd_pending;
                    if (rd_pending) begin
                        skid_data <= store_data_i;
                        skid_last <= rd_pending_last;
                    end
                end else if (rd_pending) begin
                    out.out_data_o  <= store_data_i;
                    out.out_last_o  <= rd_pending_last;
                    out.out_valid_o <= 1'b1;
                end else begin
                    out.out_valid_o <= 1'b0;
                    out.out_last_o  <= 1'b0;
                end
            end else if (rd_pending) begin
                skid_data  <= store_data_i;
                skid_last  <= rd_pending_last;
                skid_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_store_db_rd.sv
// -----------------------------------------------------------------------------
// tb_store_db_rd
// Directed bench for store_db_rd. The buffer RAM is modelled as returning
// {32{addr}} one cycle after a read. A negedge monitor logs issued reads,
// accepted words and done pulses; each test task compares the logs against
// hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_store_db_rd;
    localparam int PW = 8;
    localparam int NW = 192;
    localparam int DW = 32*PW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          store_ready = 1'b0;
    logic          store_en;
    logic [7:0]    store_addr;
    logic [DW-1:0] store_data = '0;
    logic          store_done;
    logic          busy;

    store_db_rd_if #(.PIXEL_WIDTH(PW)) sif ();

    store_db_rd #(.PIXEL_WIDTH(PW), .NUM_WORDS(NW)) dut (
        .clk          (clk),
        .rst          (rst),
        .store_ready_i(store_ready),
        .store_en_o   (store_en),
        .store_addr_o (store_addr),
        .store_data_i (store_data),
        .store_done_o (store_done),
        .busy_o       (busy),
        .out          (sif.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (store_en) store_data <= {32{store_addr}};
    end

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            addr_q[$];
    int            addr_cyc[$];
    logic [DW-1:0] word_q[$];
    bit            last_q[$];
    int            word_cyc[$];
    int            done_cyc[$];
    int            done_cnt = 0;
    int            busy_cnt = 0;
    int            stall_err = 0;
    int            occ_err = 0;
    int            n_issued = 0;
    int            n_popped = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    bit            prev_last = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            n_issued   <= 0;
            n_popped   <= 0;
            prev_stall <= 0;
        end else begin
            if (prev_stall && (!sif.out_valid_o || sif.out_data_o !== prev_data ||
                               sif.out_last_o !== prev_last))
                stall_err <= stall_err + 1;
            if (store_en && (n_issued - n_popped -
                             ((sif.out_valid_o && sif.out_ready_i) ? 1 : 0)) >= 2)
                occ_err <= occ_err + 1;
            if (store_en) begin
                addr_q.push_back(int'(store_addr));
                addr_cyc.push_back(cyc);
                n_issued <= n_issued + 1;
            end
            if (sif.out_valid_o && sif.out_ready_i) begin
                word_q.push_back(sif.out_data_o);
                last_q.push_back(sif.out_last_o);
                word_cyc.push_back(cyc);
                n_popped <= n_popped + 1;
            end
            if (store_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc.push_back(cyc);
            end
            if (busy) busy_cnt <= busy_cnt + 1;
            prev_stall <= sif.out_valid_o && !sif.out_ready_i;
            prev_data  <= sif.out_data_o;
            prev_last  <= sif.out_last_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, output bit to);
        to = 1;
        for (int i = 0; i < budget && to; i++) begin
            @(negedge clk);
            #1;
            if (done_cnt >= target) to = 0;
        end
    endtask

    task automatic wait_words(input int target, input int budget, output bit to);
        to = 1;
        for (int i = 0; i < budget && to; i++) begin
            @(negedge clk);
            #1;
            if (word_q.size() >= target) to = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        store_ready = 1'b0;
        sif.out_ready_i = 1'b0;
        tick();
        tick();
        checks++; if (store_en !== 1'b0) begin errors++; $display("FAIL reset_store_en got %b want 0", store_en); end
        checks++; if (store_addr !== 8'd0) begin errors++; $display("FAIL reset_store_addr got %0d want 0", store_addr); end
        checks++; if (store_done !== 1'b0) begin errors++; $display("FAIL reset_store_done got %b want 0", store_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (sif.out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", sif.out_valid_o); end
        checks++; if (sif.out_data_o !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", sif.out_data_o[7:0]); end
        checks++; if (sif.out_last_o !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", sif.out_last_o); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_streaming();
        int a0 = addr_q.size();
        int w0 = word_q.size();
        int d0 = done_cnt;
        int b0 = busy_cnt;
        int k;
        bit to;
        logic [7:0]    b;
        logic [DW-1:0] exp;
        sif.out_ready_i = 1'b1;
        store_ready = 1'b1;
        k = cyc;
        wait_done(d0 + 1, 400, to);
        tick();
        store_ready = 1'b0;
        repeat (4) tick();
        checks++; if (to) begin errors++; $display("FAIL stream_timeout got no done want done"); end
        checks++; if (addr_q.size() - a0 != NW) begin errors++; $display("FAIL stream_nreads got %0d want %0d", addr_q.size() - a0, NW); end
        checks++; if (word_q.size() - w0 != NW) begin errors++; $display("FAIL stream_nwords got %0d want %0d", word_q.size() - w0, NW); end
        for (int i = 0; i < NW && a0 + i < addr_q.size(); i++) begin
            checks++;
            if (addr_q[a0+i] != i || addr_cyc[a0+i] != k + 1 + i) begin
                errors++;
                $display("FAIL stream_addr[%0d] got %0d@%0d want %0d@%0d", i, addr_q[a0+i], addr_cyc[a0+i], i, k + 1 + i);
            end
        end
        for (int i = 0; i < NW && w0 + i < word_q.size(); i++) begin
            b = 8'(i);
            exp = {32{b}};
            checks++;
            if (word_q[w0+i] !== exp || word_cyc[w0+i] != k + 3 + i || last_q[w0+i] != (i == NW - 1)) begin
                errors++;
                $display("FAIL stream_word[%0d] got %h@%0d last %b want %h@%0d last %b", i, word_q[w0+i][7:0], word_cyc[w0+i], last_q[w0+i], b, k + 3 + i, i == NW - 1);
            end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL stream_done_count got %0d want 1", done_cnt - d0); end
        if (done_cyc.size() > d0) begin
            checks++; if (done_cyc[d0] != k + 3 + NW) begin errors++; $display("FAIL stream_done_cycle got %0d want %0d", done_cyc[d0], k + 3 + NW); end
        end
        checks++; if (busy_cnt - b0 != NW + 3) begin errors++; $display("FAIL stream_busy_cycles got %0d want %0d", busy_cnt - b0, NW + 3); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_after got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        int a0 = addr_q.size();
        int w0 = word_q.size();
        int d0 = done_cnt;
        int s0 = stall_err;
        int o0 = occ_err;
        bit to;
        logic [7:0]    b;
        logic [DW-1:0] exp;
        store_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            sif.out_ready_i = (i % 2 == 0);
            tick();
            store_ready = 1'b0;
        end
        for (int i = 0; i < 100; i++) begin
            sif.out_ready_i = 1'($urandom_range(0, 1));
            tick();
        end
        sif.out_ready_i = 1'b1;
        wait_done(d0 + 1, 600, to);
        tick();
        repeat (3) tick();
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got no done want done"); end
        checks++; if (word_q.size() - w0 != NW) begin errors++; $display("FAIL bp_nwords got %0d want %0d", word_q.size() - w0, NW); end
        checks++; if (addr_q.size() - a0 != NW) begin errors++; $display("FAIL bp_nreads got %0d want %0d", addr_q.size() - a0, NW); end
        for (int i = 0; i < NW && a0 + i < addr_q.size(); i++) begin
            checks++;
            if (addr_q[a0+i] != i) begin errors++; $display("FAIL bp_addr[%0d] got %0d want %0d", i, addr_q[a0+i], i); end
        end
        for (int i = 0; i < NW && w0 + i < word_q.size(); i++) begin
            b = 8'(i);
            exp = {32{b}};
            checks++;
            if (word_q[w0+i] !== exp || last_q[w0+i] != (i == NW - 1)) begin
                errors++;
                $display("FAIL bp_word[%0d] got %h last %b want %h last %b", i, word_q[w0+i][7:0], last_q[w0+i], b, i == NW - 1);
            end
        end
        checks++; if (stall_err - s0 != 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_err - s0); end
        checks++; if (occ_err - o0 != 0) begin errors++; $display("FAIL bp_en_when_full got %0d want 0", occ_err - o0); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL bp_done_count got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_full_stall();
        int a0 = addr_q.size();
        int w0 = word_q.size();
        int d0 = done_cnt;
        int s0 = stall_err;
        bit to;
        logic [7:0]    b;
        logic [DW-1:0] exp;
        sif.out_ready_i = 1'b0;
        store_ready = 1'b1;
        tick();
        store_ready = 1'b0;
        repeat (12) tick();
        checks++; if (addr_q.size() - a0 != 2) begin errors++; $display("FAIL stall_nreads got %0d want 2", addr_q.size() - a0); end
        if (addr_q.size() - a0 >= 2) begin
            checks++; if (addr_q[a0] != 0 || addr_q[a0+1] != 1) begin errors++; $display("FAIL stall_addrs got %0d,%0d want 0,1", addr_q[a0], addr_q[a0+1]); end
        end
        checks++; if (store_en !== 1'b0) begin errors++; $display("FAIL stall_en got %b want 0", store_en); end
        checks++; if (sif.out_valid_o !== 1'b1 || sif.out_data_o !== '0) begin errors++; $display("FAIL stall_head got v%b %h want v1 00", sif.out_valid_o, sif.out_data_o[7:0]); end
        checks++; if (stall_err - s0 != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stall_err - s0); end
        sif.out_ready_i = 1'b1;
        wait_done(d0 + 1, 400, to);
        tick();
        checks++; if (to) begin errors++; $display("FAIL stall_timeout got no done want done"); end
        if (addr_q.size() - a0 >= 3) begin
            checks++; if (addr_q[a0+2] != 2) begin errors++; $display("FAIL stall_resume_addr got %0d want 2", addr_q[a0+2]); end
        end
        checks++; if (addr_q.size() - a0 != NW) begin errors++; $display("FAIL stall_total_reads got %0d want %0d", addr_q.size() - a0, NW); end
        checks++; if (word_q.size() - w0 != NW) begin errors++; $display("FAIL stall_total_words got %0d want %0d", word_q.size() - w0, NW); end
        if (word_q.size() - w0 == NW) begin
            b = 8'(NW - 1);
            exp = {32{b}};
            checks++; if (word_q[w0] !== '0 || word_q[w0+NW-1] !== exp) begin errors++; $display("FAIL stall_payload got %h..%h want 00..%h", word_q[w0][7:0], word_q[w0+NW-1][7:0], b); end
        end
    endtask

    task automatic test_ready_gating();
        int a0 = addr_q.size();
        int w0 = word_q.size();
        int d0 = done_cnt;
        int b0 = busy_cnt;
        bit to;
        logic [7:0]    b;
        logic [DW-1:0] exp;
        store_ready = 1'b0;
        sif.out_ready_i = 1'b1;
        repeat (50) tick();
        checks++; if (addr_q.size() - a0 != 0) begin errors++; $display("FAIL gate_reads got %0d want 0", addr_q.size() - a0); end
        checks++; if (busy_cnt - b0 != 0 || busy !== 1'b0) begin errors++; $display("FAIL gate_busy got %0d cycles want 0", busy_cnt - b0); end
        store_ready = 1'b1;
        tick();
        store_ready = 1'b0;
        wait_done(d0 + 1, 400, to);
        tick();
        repeat (3) tick();
        checks++; if (to) begin errors++; $display("FAIL gate_timeout got no done want done"); end
        checks++; if (word_q.size() - w0 != NW) begin errors++; $display("FAIL gate_nwords got %0d want %0d", word_q.size() - w0, NW); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL gate_done_count got %0d want 1", done_cnt - d0); end
        if (word_q.size() - w0 == NW) begin
            b = 8'(NW - 1);
            exp = {32{b}};
            checks++; if (word_q[w0+NW-1] !== exp || !last_q[w0+NW-1]) begin errors++; $display("FAIL gate_last_word got %h last %b want %h last 1", word_q[w0+NW-1][7:0], last_q[w0+NW-1], b); end
        end
    endtask

    task automatic test_back_to_back();
        int a0 = addr_q.size();
        int w0 = word_q.size();
        int d0 = done_cnt;
        bit to;
        logic [7:0]    b;
        logic [DW-1:0] exp;
        store_ready = 1'b1;
        sif.out_ready_i = 1'b1;
        wait_done(d0 + 2, 800, to);
        tick();
        store_ready = 1'b0;
        repeat (4) tick();
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout got %0d dones want 2", done_cnt - d0); end
        checks++; if (done_cnt - d0 != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt - d0); end
        checks++; if (addr_q.size() - a0 != 2*NW) begin errors++; $display("FAIL b2b_nreads got %0d want %0d", addr_q.size() - a0, 2*NW); end
        if (addr_q.size() - a0 > NW && done_cyc.size() > d0) begin
            checks++; if (addr_q[a0+NW] != 0) begin errors++; $display("FAIL b2b_second_addr got %0d want 0", addr_q[a0+NW]); end
            checks++; if (addr_cyc[a0+NW] != done_cyc[d0] + 2) begin errors++; $display("FAIL b2b_restart_gap got %0d want %0d", addr_cyc[a0+NW], done_cyc[d0] + 2); end
        end
        if (word_q.size() - w0 == 2*NW) begin
            b = 8'(NW - 1);
            exp = {32{b}};
            checks++; if (word_q[w0+NW] !== '0 || word_q[w0+2*NW-1] !== exp) begin errors++; $display("FAIL b2b_payload got %h..%h want 00..%h", word_q[w0+NW][7:0], word_q[w0+2*NW-1][7:0], b); end
        end
    endtask

    task automatic test_reset_mid();
        int w0 = word_q.size();
        int d0 = done_cnt;
        int a1;
        int w1;
        bit to;
        store_ready = 1'b1;
        sif.out_ready_i = 1'b1;
        wait_words(w0 + 51, 300, to);
        checks++; if (to) begin errors++; $display("FAIL rmid_timeout got %0d words want 51", word_q.size() - w0); end
        tick();
        rst = 1'b1;
        store_ready = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (store_en !== 1'b0 || store_addr !== 8'd0 || store_done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rmid_ctrl_outputs got en%b addr%0d done%b busy%b want all 0", store_en, store_addr, store_done, busy);
        end
        checks++; if (sif.out_valid_o !== 1'b0 || sif.out_data_o !== '0 || sif.out_last_o !== 1'b0) begin
            errors++; $display("FAIL rmid_stream_outputs got v%b %h l%b want all 0", sif.out_valid_o, sif.out_data_o[7:0], sif.out_last_o);
        end
        repeat (5) tick();
        checks++; if (done_cnt - d0 != 0) begin errors++; $display("FAIL rmid_no_done got %0d want 0", done_cnt - d0); end
        a1 = addr_q.size();
        w1 = word_q.size();
        store_ready = 1'b1;
        tick();
        store_ready = 1'b0;
        wait_done(d0 + 1, 400, to);
        tick();
        checks++; if (to) begin errors++; $display("FAIL rmid_restart_timeout got no done want done"); end
        checks++; if (addr_q.size() <= a1 || addr_q[a1] != 0) begin errors++; $display("FAIL rmid_restart_addr got %0d want 0", (addr_q.size() > a1) ? addr_q[a1] : -1); end
        checks++; if (word_q.size() - w1 != NW) begin errors++; $display("FAIL rmid_nwords got %0d want %0d", word_q.size() - w1, NW); end
        if (word_q.size() > w1) begin
            checks++; if (word_q[w1] !== '0) begin errors++; $display("FAIL rmid_first_word got %h want 00", word_q[w1][7:0]); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL rmid_done_count got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        sif.out_ready_i = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_full_stall();
        test_ready_gating();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
